// File: rtl/useq_pkg.sv
// Shared types for the useq microprogram sequencer.
package useq_pkg;

  // Sequencer opcodes, I[3:0].
  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } useq_op_e;

  // Next-address source select.
  typedef enum logic [1:0] {
    SRC_D  = 2'd0,
    SRC_R  = 2'd1,
    SRC_F  = 2'd2,
    SRC_PC = 2'd3
  } useq_src_e;

  // Per-cycle decode result.
  typedef struct packed {
    useq_src_e src;
    logic      zero;
    logic      push;
    logic      pop;
    logic      clr;
    logic      r_load;
    logic      r_dec;
  } useq_ctl_t;

endpackage

// File: rtl/useq_lifo.sv
// Return-address stack for useq_sequencer: pointer, storage, top-of-stack (F),
// full flag. Optional sticky overflow/underflow flag under USEQ_STACK_ERR_EN.
module useq_lifo #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  input  logic [AW-1:0] din_i,
  output logic [AW-1:0] f_o,
  output logic          full_n_o
`ifdef USEQ_STACK_ERR_EN
  ,
  output logic          err_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] sp_q, sp_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic          full, empty, wr_en;
  logic [IW-1:0] top_idx, wr_idx;

  assign full     = (sp_q == PW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign top_idx  = IW'(sp_q - PW'(1));
  // A push into a full stack overwrites the top entry instead of growing.
  assign wr_idx   = full ? IW'(DEPTH - 1) : IW'(sp_q);
  assign f_o      = empty ? '0 : mem_q[top_idx];
  assign full_n_o = ~full;

  // Pointer next-state: clear beats push beats pop; pop on empty is a no-op.
  always_comb begin
    sp_d  = sp_q;
    wr_en = 1'b0;
    if (clr_i) begin
      sp_d = '0;
    end else if (push_i) begin
      wr_en = 1'b1;
      if (!full) sp_d = sp_q + PW'(1);
    end else if (pop_i && !empty) begin
      sp_d = sp_q - PW'(1);
    end
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Stack storage; contents are meaningless once the pointer is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= din_i;
  end

`ifdef USEQ_STACK_ERR_EN
  logic err_q;

  // Sticky overflow/underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                                     err_q <= 1'b0;
    else if ((push_i && full) || (pop_i && empty)) err_q <= 1'b1;
  end

  assign err_o = err_q;
`endif

endmodule

// File: rtl/useq_sequencer.sv
// useq_sequencer: 2910-class next-address unit. Selects Y from D, R, F or uPC
// according to opcode and condition; updates uPC, R and the stack on clk.
// Build option: define USEQ_STACK_ERR_EN to add the sticky stack_err output.
module useq_sequencer
  import useq_pkg::*;
#(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    instr,
  input  logic [AW-1:0] d,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic          ci,
  input  logic          rld_n,
  input  logic          oe_n,
  output logic [AW-1:0] y,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n,
`ifdef USEQ_STACK_ERR_EN
  output logic          stack_err,
`endif
  output logic          full_n
);

  useq_op_e      op;
  useq_ctl_t     ctl;
  logic          pass, rz;
  logic [AW-1:0] upc_q, upc_d, r_q, r_d, f, y_int;

  assign op   = useq_op_e'(instr);
  assign pass = ccen_n | ~cc_n;
  assign rz   = (r_q == '0);

  // Opcode decode: source select plus stack and R actions.
  always_comb begin
    ctl     = '0;
    ctl.src = SRC_PC;
    case (op)
      JZ:   begin ctl.zero = 1'b1; ctl.clr = 1'b1; end
      CJS:  if (pass) begin ctl.src = SRC_D; ctl.push = 1'b1; end
      JMAP: ctl.src = SRC_D;
      CJP:  if (pass) ctl.src = SRC_D;
      PUSH: begin ctl.push = 1'b1; ctl.r_load = pass; end
      JSRP: begin ctl.push = 1'b1; ctl.src = pass ? SRC_D : SRC_R; end
      CJV:  if (pass) ctl.src = SRC_D;
      JRP:  ctl.src = pass ? SRC_D : SRC_R;
      RFCT: if (!rz) begin ctl.src = SRC_F; ctl.r_dec = 1'b1; end
            else ctl.pop = 1'b1;
      RPCT: if (!rz) begin ctl.src = SRC_D; ctl.r_dec = 1'b1; end
      CRTN: if (pass) begin ctl.src = SRC_F; ctl.pop = 1'b1; end
      CJPP: if (pass) begin ctl.src = SRC_D; ctl.pop = 1'b1; end
      LDCT: ctl.r_load = 1'b1;
      LOOP: if (pass) ctl.pop = 1'b1;
            else ctl.src = SRC_F;
      CONT: ;
      TWB: begin
        if (pass) begin
          ctl.pop   = 1'b1;
          ctl.r_dec = ~rz;
        end else if (!rz) begin
          ctl.src   = SRC_F;
          ctl.r_dec = 1'b1;
        end else begin
          ctl.src = SRC_D;
          ctl.pop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next-address multiplexer.
  always_comb begin
    y_int = upc_q;
    case (ctl.src)
      SRC_D:   y_int = d;
      SRC_R:   y_int = r_q;
      SRC_F:   y_int = f;
      default: y_int = upc_q;
    endcase
    if (ctl.zero) y_int = '0;
  end

  assign y      = oe_n ? 'z : y_int;
  assign pl_n   = (op == JMAP) || (op == CJV);
  assign map_n  = (op != JMAP);
  assign vect_n = (op != CJV);

  // uPC and R next-state; an external R load overrides any opcode R action.
  always_comb begin
    upc_d = y_int + AW'(ci);
    r_d   = r_q;
    if (!rld_n)                r_d = d;
    else if (ctl.r_load)       r_d = d;
    else if (ctl.r_dec && !rz) r_d = r_q - AW'(1);
  end

  // uPC and loop counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

  useq_lifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (ctl.push),
    .pop_i    (ctl.pop),
    .clr_i    (ctl.clr),
    .din_i    (upc_q),
    .f_o      (f),
    .full_n_o (full_n)
`ifdef USEQ_STACK_ERR_EN
    ,
    .err_o    (stack_err)
`endif
  );

endmodule

// File: tb/tb_useq_sequencer.sv
// Scoreboard bench for useq_sequencer: driver pushes reference-model
// expectations, monitor pops and compares once per cycle.
module tb_useq_sequencer;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst, cc_n, ccen_n, ci, rld_n, oe_n;
  logic [3:0]    instr;
  logic [AW-1:0] d;
  logic [AW-1:0] y;
  logic          pl_n, map_n, vect_n, full_n;
  logic          err_obs;

  useq_sequencer #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .d         (d),
    .cc_n      (cc_n),
    .ccen_n    (ccen_n),
    .ci        (ci),
    .rld_n     (rld_n),
    .oe_n      (oe_n),
    .y         (y),
    .pl_n      (pl_n),
    .map_n     (map_n),
    .vect_n    (vect_n),
`ifdef USEQ_STACK_ERR_EN
    .stack_err (err_obs),
`endif
    .full_n    (full_n)
  );

`ifndef USEQ_STACK_ERR_EN
  assign err_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] y;
    bit            pl_n, map_n, vect_n, full_n, err;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state: plain integers and a queue as the stack.
  int m_pc, m_r;
  int m_stk[$];
  bit m_err;
  int cyc_no;

  int n_pass  = 0;
  int n_total = 0;

  task automatic step(input int op, input int dv, input bit ccn, input bit ccenn,
                      input bit civ, input bit rldn, input bit rstv, input bit chk);
    exp_t e;
    int   yv, f;
    bit   pass, rz, do_push, do_pop, do_clr, ldr, dec;
    @(negedge clk);
    instr  = op[3:0];
    d      = dv[AW-1:0];
    cc_n   = ccn;
    ccen_n = ccenn;
    ci     = civ;
    rld_n  = rldn;
    rst    = rstv;
    oe_n   = 1'b0;
    dv      = dv % (1 << AW);
    pass    = ccenn | ~ccn;
    rz      = (m_r == 0);
    f       = (m_stk.size() > 0) ? m_stk[$] : 0;
    do_push = 0; do_pop = 0; do_clr = 0; ldr = 0; dec = 0;
    yv      = m_pc;
    case (op)
      0:  begin yv = 0; do_clr = 1; end
      1:  if (pass) begin yv = dv; do_push = 1; end
      2:  yv = dv;
      3:  if (pass) yv = dv;
      4:  begin do_push = 1; ldr = pass; end
      5:  begin yv = pass ? dv : m_r; do_push = 1; end
      6:  if (pass) yv = dv;
      7:  yv = pass ? dv : m_r;
      8:  if (!rz) begin yv = f; dec = 1; end else do_pop = 1;
      9:  if (!rz) begin yv = dv; dec = 1; end
      10: if (pass) begin yv = f; do_pop = 1; end
      11: if (pass) begin yv = dv; do_pop = 1; end
      12: ldr = 1;
      13: if (pass) do_pop = 1; else yv = f;
      14: ;
      default: begin
        if (pass) begin do_pop = 1; dec = !rz; end
        else if (!rz) begin yv = f; dec = 1; end
        else begin yv = dv; do_pop = 1; end
      end
    endcase
    e.y      = yv[AW-1:0];
    e.pl_n   = (op == 2) || (op == 6);
    e.map_n  = (op != 2);
    e.vect_n = (op != 6);
    e.full_n = (m_stk.size() != DEPTH);
    e.err    = m_err;
    e.cyc    = cyc_no;
    cyc_no++;
    if (chk) sb.push_back(e);
    if (rstv) begin
      m_pc = 0; m_r = 0; m_err = 0;
      m_stk.delete();
    end else begin
      if (do_clr) m_stk.delete();
      if (do_push) begin
        if (m_stk.size() == DEPTH) begin
          m_stk[DEPTH-1] = m_pc;
          m_err = 1;
        end else m_stk.push_back(m_pc);
      end
      if (do_pop) begin
        if (m_stk.size() == 0) m_err = 1;
        else void'(m_stk.pop_back());
      end
      if (!rldn)              m_r = dv;
      else if (ldr)           m_r = dv;
      else if (dec && m_r > 0) m_r = m_r - 1;
      m_pc = (yv + int'(civ)) % (1 << AW);
    end
  endtask

  // Monitor: one compare per cycle, sampled mid-low-phase.
  initial begin
    bit ok;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_total++;
        ok = (y === mon_e.y) && (pl_n === mon_e.pl_n) && (map_n === mon_e.map_n) &&
             (vect_n === mon_e.vect_n) && (full_n === mon_e.full_n);
`ifdef USEQ_STACK_ERR_EN
        ok = ok && (err_obs === mon_e.err);
`endif
        if (ok) n_pass++;
        else
          $display("FAIL cyc%0d outputs: got y=%h pl_n=%b map_n=%b vect_n=%b full_n=%b err=%b, expected y=%h pl_n=%b map_n=%b vect_n=%b full_n=%b err=%b",
                   mon_e.cyc, y, pl_n, map_n, vect_n, full_n, err_obs,
                   mon_e.y, mon_e.pl_n, mon_e.map_n, mon_e.vect_n, mon_e.full_n, mon_e.err);
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    cyc_no = 0;
    m_pc = 0; m_r = 0; m_err = 0;
    step(14, 0, 1, 1, 1, 1, 1, 0);                         // reset, state unknown
    for (int i = 0; i < 5; i++) step(14, 0, 1, 1, 1, 1, 0, 1); // y = 0..4
    step(1, 'h40, 0, 0, 1, 1, 0, 1);                       // CJS pass, push 5
    step(10, 0, 0, 0, 1, 1, 0, 1);                         // CRTN -> 5
    step(12, 2, 1, 1, 1, 1, 0, 1);                         // LDCT 2
    for (int i = 0; i < 3; i++) step(9, 'h10, 1, 1, 1, 1, 0, 1); // RPCT x3
    for (int i = 0; i <= DEPTH; i++) step(4, i + 1, 1, 1, 1, 1, 0, 1); // overfill
    step(14, 0, 1, 1, 1, 1, 0, 1);                         // full_n low
    step(0, 0, 1, 1, 1, 1, 0, 1);                          // JZ clears
    step(10, 0, 0, 0, 1, 1, 0, 1);                         // CRTN on empty, y=0
    step(14, 0, 1, 1, 1, 1, 0, 1);
    step(1, 'h80, 0, 0, 1, 1, 0, 1);                       // push one
    step(12, 0, 1, 1, 1, 1, 0, 1);                         // R = 0
    step(15, 'h123, 1, 0, 1, 1, 0, 1);                     // TWB RZ fail -> D, pop
    step(14, 0, 1, 1, 1, 1, 0, 1);
    step(1, 'h90, 0, 0, 1, 1, 0, 1);                       // push one
    step(12, 3, 1, 1, 1, 1, 0, 1);                         // R = 3
    step(8, 7, 1, 1, 1, 0, 0, 1);                          // RFCT with rld_n=0
    step(7, 0, 1, 0, 1, 1, 0, 1);                          // JRP fail -> R (7)
    step(4, 5, 1, 1, 1, 1, 0, 1);
    step(4, 6, 1, 1, 1, 1, 0, 1);
    step(14, 0, 1, 1, 1, 1, 1, 1);                         // mid-sequence reset
    step(10, 0, 0, 0, 1, 1, 0, 1);                         // stack gone, y=0
    step(14, 0, 1, 1, 0, 1, 0, 1);                         // ci=0 holds uPC
    step(14, 0, 1, 1, 1, 1, 0, 1);
    for (int i = 0; i < 400; i++)
      step(int'($urandom_range(0, 15)), int'($urandom_range(0, (1 << AW) - 1)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 99) == 0), 1'b1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #3;
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
